// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the weighted round-robin arbiter
package arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int MAX_REQ = 32;
  function automatic int w2c(input int w);
    return w == 0 ? 1 : w;
  endfunction
  function automatic int rr_first(input logic [MAX_REQ-1:0] req, input int n, input int ptr);
    int j;
    rr_first = ptr;
    for (int k = n; k >= 1; k--) begin
      j = ptr + k;
      j = j >= n ? j - n : j;
      if (req[5'(j)]) rr_first = j;
    end
  endfunction
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: round-robin pick of the first request after ptr, wrapping
module arb_rr_pick import arb_pkg::*; #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);
  // rotate from ptr+1 and take the first set request
  always_comb begin
    idx = IW'(rr_first(MAX_REQ'(req), N, int'(ptr)));
    pick = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/arb_wrr.sv
// arb_wrr: weighted round-robin arbiter with registered output; ARB_WRR_PKT_LOCK_EN enables packet locking
module arb_wrr import arb_pkg::*; #(
  parameter int REQ_WIDTH = 4,
  parameter int DW = 8,
  parameter int WW = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REQ_WIDTH-1:0]    valid_in,
  input  logic [REQ_WIDTH*DW-1:0] data_in,
  input  logic [REQ_WIDTH-1:0]    last_in,
  input  logic [REQ_WIDTH*WW-1:0] weight_in,
  output logic [REQ_WIDTH-1:0]    ready_out,
  output logic                    valid_out,
  output logic [DW-1:0]           data_out,
  output logic                    last_out,
  output logic [REQ_WIDTH-1:0]    grant_out,
  input  logic                    ready_in
);
  localparam int IW = $clog2(REQ_WIDTH);
  state_t state;
  logic [REQ_WIDTH-1:0] grant, pick_i, pick_r;
  logic [IW-1:0] gidx, ptr, idx_i, idx_r;
  logic [WW-1:0] credit, w_i, w_r;
  logic [DW-1:0] cur_d;
  logic cur_v, cur_l, acc, unit, hold, rel;
  assign ready_out = grant & {REQ_WIDTH{~valid_out | ready_in}};
  assign grant_out = grant;
  assign acc = |(valid_in & ready_out);
  assign rel = (state == BUSY) & ((unit & (credit == WW'(1))) | (~cur_v & ~hold));
  arb_rr_pick #(.N(REQ_WIDTH)) u_pick_i (.req(valid_in), .ptr(ptr), .pick(pick_i), .idx(idx_i));
  arb_rr_pick #(.N(REQ_WIDTH)) u_pick_r (.req(valid_in), .ptr(gidx), .pick(pick_r), .idx(idx_r));
  // route the granted channel and fetch the weights of both candidates
  always_comb begin
    cur_d = '0;
    cur_v = 1'b0;
    cur_l = 1'b0;
    w_i = '0;
    w_r = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (IW'(i) == gidx) begin
        cur_d = data_in[i*DW +: DW];
        cur_v = valid_in[i];
        cur_l = last_in[i];
      end
      if (IW'(i) == idx_i) w_i = WW'(w2c(int'(weight_in[i*WW +: WW])));
      if (IW'(i) == idx_r) w_r = WW'(w2c(int'(weight_in[i*WW +: WW])));
    end
  end
`ifdef ARB_WRR_PKT_LOCK_EN
  logic mid;
  assign unit = acc & cur_l;
  assign hold = mid;
  // remember whether the granted channel is inside a packet
  always_ff @(posedge clk or negedge rst)
    if (!rst) mid <= 1'b0;
    else if (acc) mid <= ~cur_l;
  // end-of-packet travels with its beat
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_out <= 1'b0;
    else if (acc) last_out <= cur_l;
`else
  logic unused_l;
  assign unit = acc;
  assign hold = 1'b0;
  assign unused_l = cur_l;
  assign last_out = 1'b0;
`endif
  // grant FSM: pick on idle, re-arbitrate without a bubble on release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      gidx <= '0;
      credit <= '0;
      ptr <= IW'(REQ_WIDTH - 1);
    end else if (state == IDLE) begin
      if (|valid_in) begin
        state <= BUSY;
        grant <= pick_i;
        gidx <= idx_i;
        credit <= w_i;
      end
    end else if (rel) begin
      ptr <= gidx;
      if (|valid_in) begin
        grant <= pick_r;
        gidx <= idx_r;
        credit <= w_r;
      end else begin
        state <= IDLE;
        grant <= '0;
        credit <= '0;
      end
    end else if (unit) begin
      credit <= credit - WW'(1);
    end
  end
  // output register: load on accept, drain when the sink takes the beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      data_out <= '0;
    end else if (acc) begin
      valid_out <= 1'b1;
      data_out <= cur_d;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_wrr.sv
// tb_arb_wrr: directed and randomized checks of arb_wrr against a behavioural model
module tb_arb_wrr;
  localparam int N = 4;
`ifdef ARB_WRR_PKT_LOCK_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] valid_in, last_in, ready_out, grant_out;
  logic [N*8-1:0] data_in;
  logic [N*4-1:0] weight_in;
  logic valid_out, last_out, ready_in;
  logic [7:0] data_out;
  int total = 0;
  int bad = 0;
  int m_own, m_cred, m_ptr;
  bit m_mid, m_vo, m_lo;
  logic [7:0] m_do;
  logic [7:0] exp1 [4] = '{8'h21, 8'h43, 8'h65, 8'h87};
  logic [7:0] exp3 [6] = '{8'h21, 8'h21, 8'h21, 8'h43, 8'h65, 8'h87};

  arb_wrr dut (.clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
    .weight_in(weight_in), .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
    .last_out(last_out), .grant_out(grant_out), .ready_in(ready_in));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wt(int j);
    int w = int'(weight_in[j*4 +: 4]);
    return w == 0 ? 1 : w;
  endfunction

  function automatic int nxt(int p);
    for (int k = 1; k <= N; k++)
      if (valid_in[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_cred = 0; m_ptr = N - 1; m_mid = 0; m_vo = 0; m_do = 0; m_lo = 0;
  endtask

  task automatic model_step();
    int own = m_own;
    int j;
    bit rdy = own >= 0 && (!m_vo || ready_in);
    bit acc = rdy ? valid_in[own] : 1'b0;
    bit lst = own >= 0 ? last_in[own] : 1'b0;
    bit unit = acc && (!PKT || lst);
    bit rel;
    if (acc) begin
      m_vo = 1; m_do = data_in[own*8 +: 8]; m_lo = PKT && lst;
    end else if (ready_in) m_vo = 0;
    if (own < 0) begin
      j = nxt(m_ptr);
      if (j >= 0) begin m_own = j; m_cred = wt(j); end
    end else begin
      rel = (unit && m_cred == 1) || (!valid_in[own] && !(PKT && m_mid));
      if (acc) m_mid = !lst;
      if (rel) begin
        m_ptr = own;
        j = nxt(own);
        if (j >= 0) begin m_own = j; m_cred = wt(j); end
        else begin m_own = -1; m_cred = 0; end
      end else if (unit) m_cred--;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] g = m_own >= 0 ? N'(1) << m_own : '0;
    check("valid_out", valid_out, m_vo);
    check("data_out", data_out, m_do);
    check("last_out", last_out, m_lo);
    check("grant_out", grant_out, g);
    check("ready_out", ready_out, (!m_vo || ready_in) ? g : '0);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_reset(); else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic restart(input logic [15:0] w, input logic [3:0] v);
    rst = 0; weight_in = w; valid_in = v; last_in = 0; ready_in = 1;
    model_reset();
    cyc();
    rst = 1;
  endtask

  initial begin
    rst = 0; valid_in = 0; data_in = 0; last_in = 0; weight_in = 16'h1111; ready_in = 1;
    model_reset();
    repeat (2) cyc();
    check("reset_valid", valid_out, 0);
    check("reset_grant", grant_out, 0);
    valid_in = 4'hf; data_in = 32'h87654321;
    rst = 1;
    cyc();
    check("t1_lat_valid", valid_out, 0);
    check("t1_first_grant", grant_out, 4'b0001);
    cyc();
    check("t1_first_valid", valid_out, 1);
    check("t1_first_data", data_out, 8'h21);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("t1_seq", data_out, exp1[i % 4]);
    end
    ready_in = 0;
    #1 check("t2_ready_low", ready_out, 0);
    cyc();
    check("t2_hold_data", data_out, 8'h21);
    check("t2_hold_valid", valid_out, 1);
    ready_in = 1;
    cyc();
    check("t2_resume", data_out, 8'h43);
    cyc();
    check("t2_next", data_out, 8'h65);
    #2 rst = 0;
    #1;
    check("t6_valid", valid_out, 0);
    check("t6_data", data_out, 0);
    check("t6_last", last_out, 0);
    check("t6_grant", grant_out, 0);
    check("t6_ready", ready_out, 0);
    model_reset();
    cyc();
    rst = 1;
    cyc();
    check("t6_regrant", grant_out, 4'b0001);
    cyc();
    check("t6_restart", data_out, 8'h21);
    restart(16'h1103, 4'hf);
    cyc();
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("t3_weighted", data_out, exp3[i % 6]);
    end
    restart(16'h1211, 4'b0100);
    cyc();
    check("t4_grant", grant_out, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t4_steady", grant_out, 4'b0100);
      check("t4_data", data_out, 8'h65);
    end
    valid_in = 0;
    cyc();
    check("t4_idle", grant_out, 0);
    cyc();
    check("t4_idle2", grant_out, 0);
    valid_in = 4'b0001;
    cyc();
    check("t4_ch0", grant_out, 4'b0001);
`ifdef ARB_WRR_PKT_LOCK_EN
    restart(16'h1111, 4'b0011);
    cyc();
    check("t5_grant0", grant_out, 4'b0001);
    cyc();
    check("t5_beat1", data_out, 8'h21);
    check("t5_beat1_last", last_out, 0);
    valid_in = 4'b0010;
    cyc();
    check("t5_lock1", grant_out, 4'b0001);
    cyc();
    check("t5_lock2", grant_out, 4'b0001);
    valid_in = 4'b0011;
    cyc();
    check("t5_beat2_grant", grant_out, 4'b0001);
    check("t5_beat2_last", last_out, 0);
    last_in = 4'b0001;
    cyc();
    check("t5_beat3_last", last_out, 1);
    check("t5_beat3_data", data_out, 8'h21);
    check("t5_switch", grant_out, 4'b0010);
    last_in = 0;
    cyc();
    check("t5_ch1_data", data_out, 8'h43);
    check("t5_ch1_last", last_out, 0);
`endif
    for (int ph = 0; ph < 3; ph++) begin
      restart(16'($urandom), 4'($urandom));
      for (int c = 0; c < 1500; c++) begin
        valid_in = 4'($urandom | $urandom);
        last_in = 4'($urandom & $urandom);
        data_in = $urandom;
        ready_in = $urandom_range(0, 3) != 0;
        cyc();
        if ($urandom_range(0, 199) == 0) begin
          #2 rst = 0;
          #1;
          check("rnd_async_valid", valid_out, 0);
          check("rnd_async_grant", grant_out, 0);
          model_reset();
          cyc();
          rst = 1;
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arb_wrr.md
# arb_wrr

Weighted round-robin arbiter with packet locking and a registered output stage; it generalises the team's single-beat round-robin arbiter. It merges REQ_WIDTH valid/ready source channels onto one valid/ready sink. Each channel gets a programmable number of consecutive grants (its weight) before priority rotates. It sits between the per-port ingress queues and the shared egress path.

## Interface
- REQ_WIDTH, 4, number of request channels (≥2)
- DW, 8, data width per channel
- WW, 4, weight field width per channel
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- valid_in  input  REQ_WIDTH  per-channel valid
- data_in  input  REQ_WIDTH*DW  channel i at bits [i*DW +: DW]
- last_in  input  REQ_WIDTH  per-channel end-of-packet marker
- weight_in  input  REQ_WIDTH*WW  channel i weight at [i*WW +: WW]; quasi-static
- ready_out  output  REQ_WIDTH  per-channel ready
- valid_out  output  1  sink valid
- data_out  output  DW  sink data
- last_out  output  1  sink end-of-packet
- grant_out  output  REQ_WIDTH  one-hot registered grant (debug/status)
- ready_in  input  1  sink ready

## Operation
- Channel i beat is accepted when valid_in[i] & ready_out[i]. Sink beat completes when valid_out & ready_in.
- ready_out[i] = grant[i] & (~valid_out | ready_in). Only the granted channel is ever ready.
- The output register loads data_in/last_in of the granted channel on accept. It clears valid_out when the sink takes a beat and no new beat is accepted.
- States: IDLE (no grant) and BUSY (grant held).
- IDLE: if any valid_in, the channel is picked round-robin starting at ptr+1 (wrapping). The grant is registered, credit ← weight of that channel, and the state goes to BUSY. A weight of 0 is treated as 1.
- BUSY: credit decrements on each accepted credit-unit (beat, or last beat in packet mode).
- On the unit that takes credit from 1 to 0, the grant is released and ptr ← the granted index.
- In the same cycle, the next channel is arbitrated from ptr+1 using the current valid_in, so there is no bubble if another channel is valid.
- If no other channel is valid but the released one is, it is re-granted with fresh credit.
- If nothing is valid, the state goes to IDLE.
- Granted channel with valid_in low:
  - Packet mode: the grant is held if mid-packet.
  - Otherwise: the grant is released with the same pointer update. Remaining credit is forfeited.
- Credit counter width is WW; weight 2^WW-1 is the maximum.

## Timing
- Reset (rst low, async) sets: valid_out=0, data_out=0, last_out=0, ready_out=0, grant_out=0, credit=0, state=IDLE, ptr=REQ_WIDTH-1 (so channel 0 wins first).
- Latency: first edge after reset release registers the grant. Second edge captures the first beat. valid_out is high after that second edge.
- Throughput: one beat per cycle while ready_in stays high, including across grant switches.
- ready_in low with valid_out high: data_out/last_out hold and ready_out is all 0. When ready_in rises, transfer resumes in the same cycle.
- Reset asserted mid-packet: all state is cleared immediately and the partial packet is dropped at the output.

## Configuration
- ARB_WRR_PKT_LOCK_EN defined:
  - The grant is never released between the first and last beat of a packet.
  - Credit is counted per packet (decrements on the accepted beat with last_in=1).
  - last_out mirrors the captured last_in.
- Undefined:
  - last_in is ignored and credit is counted per beat.
  - A granted channel going invalid releases immediately.
  - last_out is constant 0.

## Structure
- Package arb_pkg holds:
  - the state enum (IDLE, BUSY)
  - the weight-to-credit function (0→1)
  - the rotate-and-find-first helper function
- Sub-module arb_rr_pick: combinational; inputs req and ptr, outputs a one-hot pick and an index. It is used for both the IDLE and release paths.
- Top level holds the FSM, credit counter, pointer and output register.

## Test plan
1. REQ_WIDTH=4, DW=8, all weights 1, valid_in=4'b1111, data_in=32'h87654321, ready_in=1, no packets.
   - Expected data_out: 21,43,65,87,21… one per cycle.
   - valid_out is first high 2 edges after reset release.
2. Same setup, ready_in low for one cycle mid-stream.
   - data_out holds its value and ready_out=0 for that cycle.
   - The sequence resumes with no lost or duplicated byte.
3. Weights {ch3..ch0}={1,1,1,3}, all valid.
   - Output: 21,21,21,43,65,87, repeating.
   - Weight 0 on ch1 behaves as weight 1.
4. Only ch2 valid, weight 2.
   - Continuous re-grant to ch2, grant_out=4'b0100 steady.
   - ch2 deasserts → IDLE with grant_out=0. ch0 asserts next → grant_out=4'b0001.
5. With ARB_WRR_PKT_LOCK_EN: ch0 sends a 3-beat packet, all weights 1, ch1 valid throughout, ch0 drops valid for 2 cycles after beat 1.
   - The grant stays on ch0 until its last beat.
   - Then ch1 is granted the next cycle; last_out is high only on ch0's third beat.
6. Assert rst mid-packet with valid_out high.
   - All outputs are 0 immediately, without waiting for a clock edge.
   - After release, arbitration restarts from channel 0.
